des_round_engine: RTL and testbench

DES_ROUND_ENGINE -- requirements
Module: des_round_engine

---
 rtl/des_pkg.sv | 126 ++++++++++++
 rtl/feistel_f.sv | 23 ++
 rtl/des_round_engine.sv | 106 ++++++++++
 tb/tb_des_round_engine.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES constant tables, FSM state encoding and small table-driven helpers.
// Latency: none (constants and pure combinational functions).
// Backpressure: not applicable.
// DES numbers bits from 1 at the MSB, so table entry t selects vector bit (width - t).
package des_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ROUND = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Each box is stored row-major: entry = row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

    // Left-rotate amount applied before PC2 in encrypt rounds 1..16.
    localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
        return o;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] r);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = r[32-E_TBL[i]];
        return o;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] s);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[31-i] = s[32-P_TBL[i]];
        return o;
    endfunction

    // Row comes from the outer two bits, column from the inner four.
    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] x);
        int v;
        v = SBOX[box][{x[5], x[0], x[4:1]}];
        return v[3:0];
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                          input logic right);
        logic [27:0] o;
        case (amt)
            2'd1:    o = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
            2'd2:    o = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
            default: o = x;
        endcase
        return o;
    endfunction

    // Decrypt walks the encrypt schedule backwards with right rotations; round 1
    // uses the unrotated halves since 16 encrypt rounds rotate a full 28 bits.
    function automatic logic [1:0] shift_amount(input logic [3:0] cnt, input logic dec);
        int v;
        int idx;
        idx = 16 - int'(cnt);
        if (!dec)            v = ENC_SHIFT[cnt];
        else if (cnt == 4'd0) v = 0;
        else                 v = ENC_SHIFT[idx[3:0]];
        return v[1:0];
    endfunction

endpackage

// File: rtl/feistel_f.sv
// DES round function f(R,K) = P(S(E(R) xor K)); ports: r_in[31:0], k_in[47:0] -> f_out[31:0].
// Latency: purely combinational.
// Backpressure: none.
module feistel_f (
    input  logic [31:0] r_in,
    input  logic [47:0] k_in,
    output logic [31:0] f_out
);
    import des_pkg::*;

    logic [47:0] x;
    logic [31:0] s;

    always_comb begin
        x = e_expand(r_in) ^ k_in;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[31-4*i -: 4] = sbox_lookup(i, x[47-6*i -: 6]);
        end
        f_out = p_perm(s);
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES core: one Feistel round per clock over a post-IP block, output {R16,L16}.
// Latency: 16 cycles from accept edge to out_valid; in_ready only while idle.
// Backpressure: result held in DONE until out_ready; inputs ignored while busy.
// Ports: clk/rst_n; in_valid/in_ready + block_in/key/decrypt; out_valid/out_ready + block_out.
module des_round_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] block_in,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] block_out
);
    import des_pkg::*;

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;

    logic [1:0]  shamt;
    logic [27:0] c_rot;
    logic [27:0] d_rot;
    logic [47:0] subkey;
    logic [31:0] f_out;

    // Subkey for the round indexed by cnt_q; the rotated halves become the new C/D.
    always_comb begin
        shamt  = shift_amount(cnt_q, dec_q);
        c_rot  = rot28(c_q, shamt, dec_q);
        d_rot  = rot28(d_q, shamt, dec_q);
        subkey = pc2_perm({c_rot, d_rot});
    end

    feistel_f u_feistel_f (
        .r_in  (r_q),
        .k_in  (subkey),
        .f_out (f_out)
    );

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    l_d        = block_in[63:32];
                    r_d        = block_in[31:0];
                    {c_d, d_d} = pc1_perm(key);
                    dec_d      = decrypt;
                    cnt_d      = 4'd0;
                    state_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                c_d   = c_rot;
                d_d   = d_rot;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

    // After round 16 the halves sit in L/R; emitting {R,L} undoes the last swap.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign block_out = {r_q, l_q};

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: wraps the core with IP / inverse-IP and compares against a DES model.
// Latency: expects 16 cycles accept-to-valid.
// Backpressure: exercises out_ready stalls, mid-op reset and input toggling.
module tb_des_round_engine;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] block_in;
    logic [63:0] key;
    logic        decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] block_out;

    int n_checks = 0;
    int n_fail   = 0;

    des_round_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .block_in  (block_in),
        .key       (key),
        .decrypt   (decrypt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .block_out (block_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- reference DES model (bit-numbered from 1 at MSB) ----------------
    localparam int M_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int M_FP [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int M_E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int M_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int M_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int M_S [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [63:0] m_ip(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-M_IP[i]];
        return o;
    endfunction

    function automatic logic [63:0] m_fp(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-M_FP[i]];
        return o;
    endfunction

    function automatic logic [27:0] m_rotl(input logic [27:0] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  six;
        int          v;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-M_E[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            v   = M_S[b][(2*six[5] + six[0]) * 16 + int'(six[4:1])];
            s[31-4*b -: 4] = v[3:0];
        end
        for (int i = 0; i < 32; i++) o[31-i] = s[32-M_P[i]];
        return o;
    endfunction

    // Full DES on a plaintext: subkeys from cumulative left shifts, reversed for decrypt.
    function automatic logic [63:0] des_model(input logic [63:0] k, input logic [63:0] pt,
                                              input bit dec);
        logic [55:0] cd;
        logic [55:0] rcd;
        logic [47:0] ks [16];
        logic [31:0] l, r, t;
        logic [63:0] b;
        int          tot;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-M_PC1[i]];
        tot = 0;
        for (int n = 0; n < 16; n++) begin
            tot += M_SHIFTS[n];
            rcd = {m_rotl(cd[55:28], tot), m_rotl(cd[27:0], tot)};
            for (int i = 0; i < 48; i++) ks[n][47-i] = rcd[56-M_PC2[i]];
        end
        b = m_ip(pt);
        l = b[63:32];
        r = b[31:0];
        for (int n = 0; n < 16; n++) begin
            t = r;
            r = l ^ m_f(r, dec ? ks[15-n] : ks[n]);
            l = t;
        end
        return m_fp({r, l});
    endfunction

    // ---------------- checking and driving ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One complete operation through IP -> engine -> inverse IP. hold = stall cycles
    // with out_ready low; toggle = scramble inputs (and out_ready) while busy.
    task automatic run_op(input logic [63:0] k, input logic [63:0] pt, input bit dec,
                          input bit toggle, input int hold,
                          output logic [63:0] res, output int lat);
        int          w;
        logic [63:0] snap;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        block_in = m_ip(pt);
        key      = k;
        decrypt  = dec;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        res = '0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            if (toggle) begin
                in_valid  = 1'($urandom_range(0, 1));
                block_in  = {$urandom, $urandom};
                key       = {$urandom, $urandom};
                decrypt   = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!out_valid) begin
            check("out_valid_timeout", 64'(out_valid), 64'd1);
        end else begin
            snap = block_out;
            res  = m_fp(block_out);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("stall_block_out", block_out, snap);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_in_ready", 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("release_out_valid", 64'(out_valid), 64'd0);
            check("release_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    typedef struct {
        logic [63:0] k;
        logic [63:0] pt;
        bit          dec;
        logic [63:0] exp;
    } vec_t;

    initial begin
        vec_t        vt [6];
        logic [63:0] res;
        logic [63:0] r1;
        logic [63:0] rk;
        logic [63:0] rp;
        bit          rd;
        int          lat;
        int          seen;

        vt[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
        vt[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
        vt[2] = '{64'h0101010101010101, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
        vt[3] = '{64'h0101010101010101, 64'h8CA64DE9C1B123A7, 1'b0, 64'h0000000000000000};
        vt[4] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
        vt[5] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        block_in  = '0;
        key       = '0;
        decrypt   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_block_out", block_out, 64'd0);
        rst_n = 1'b1;

        // Known-answer table, with a different stall length per entry.
        for (int i = 0; i < 6; i++) begin
            run_op(vt[i].k, vt[i].pt, vt[i].dec, 1'b0, i % 3, res, lat);
            check($sformatf("vec%0d_result", i), res, vt[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
        end

        // Weak key: encrypting twice with output fed back returns the plaintext.
        run_op(64'h0101010101010101, 64'h0, 1'b0, 1'b0, 0, r1, lat);
        run_op(64'h0101010101010101, r1, 1'b0, 1'b0, 0, res, lat);
        check("weak_key_roundtrip", res, 64'h0);

        // Five-cycle stall on the known-answer vector.
        run_op(vt[0].k, vt[0].pt, 1'b0, 1'b0, 5, res, lat);
        check("stall5_result", res, vt[0].exp);

        // Reset after round 8 aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        block_in = m_ip(64'h0123456789ABCDEF);
        key      = 64'h133457799BBCDFF1;
        decrypt  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_block_out", block_out, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", 64'(seen), 64'd0);
        check("abort_idle_in_ready", 64'(in_ready), 64'd1);
        run_op(vt[0].k, vt[0].pt, 1'b0, 1'b0, 0, res, lat);
        check("after_abort_result", res, vt[0].exp);
        check("after_abort_latency", 64'(lat), 64'd16);

        // Inputs scrambled every cycle while busy must not disturb the result.
        run_op(vt[0].k, vt[0].pt, 1'b0, 1'b1, 1, res, lat);
        check("toggle_result", res, vt[0].exp);
        check("toggle_latency", 64'(lat), 64'd16);

        // Random vectors against the reference model.
        for (int i = 0; i < 20; i++) begin
            rk = {$urandom, $urandom};
            rp = {$urandom, $urandom};
            rd = 1'($urandom_range(0, 1));
            run_op(rk, rp, rd, i[0], $urandom_range(0, 2), res, lat);
            check($sformatf("rand%0d_result", i), res, des_model(rk, rp, rd));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
